// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_pkg
// Brief   : Shared opcodes, encodings and enums for the multi-cycle RV32I core.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OPIMM   = 4'd1,
        CLS_LUI     = 4'd2,
        CLS_AUIPC   = 4'd3,
        CLS_LOAD    = 4'd4,
        CLS_STORE   = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_e;

    localparam logic [1:0] PC_SRC_PC4  = 2'd0;
    localparam logic [1:0] PC_SRC_ALU  = 2'd1;
    localparam logic [1:0] PC_SRC_TRAP = 2'd2;

    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_CMP   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5,
        ST_FAULT   = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module  : opcode_decoder
// Brief   : Combinational opcode to instruction class and immediate format.
// Revision: 1.0 - initial release
// ============================================================================
module opcode_decoder
    import core_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [3:0] o_class,
    output logic [2:0] o_imm_type
);

    always_comb begin
        o_class    = CLS_ILLEGAL;
        o_imm_type = IMM_I;
        case (i_opcode)
            OPC_OP:     o_class = CLS_OP;
            OPC_OPIMM:  o_class = CLS_OPIMM;
            OPC_LOAD:   o_class = CLS_LOAD;
            OPC_JALR:   o_class = CLS_JALR;
            OPC_LUI:    begin o_class = CLS_LUI;    o_imm_type = IMM_U; end
            OPC_AUIPC:  begin o_class = CLS_AUIPC;  o_imm_type = IMM_U; end
            OPC_STORE:  begin o_class = CLS_STORE;  o_imm_type = IMM_S; end
            OPC_BRANCH: begin o_class = CLS_BRANCH; o_imm_type = IMM_B; end
            OPC_JAL:    begin o_class = CLS_JAL;    o_imm_type = IMM_J; end
            default:    o_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_controller
// Brief   : Main FSM of the multi-cycle RV32I core with memory timeout fault.
//           Build option: ILLEGAL_TRAP_EN routes unknown opcodes to a TRAP state.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_controller
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_type,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_retired,
    output logic       trap,
    output logic       fault
);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_fault;
    logic [3:0]         w_cls_raw;
    logic [2:0]         w_imm_raw;
    instr_class_e       w_cls;
    logic               w_timeout;
    logic               w_is_jump;
    logic               w_unused_funct3;

    opcode_decoder u_decoder (
        .i_opcode   (opcode),
        .o_class    (w_cls_raw),
        .o_imm_type (w_imm_raw)
    );

    assign w_cls     = instr_class_e'(w_cls_raw);
    assign w_is_jump = (w_cls == CLS_JAL) || (w_cls == CLS_JALR);
    // Limit is reached on the cycle the counter would become MEM_TIMEOUT.
    assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ready;
    // The ALU consumes funct3 directly; the controller only selects compare mode.
    assign w_unused_funct3 = ^funct3;
    assign fault     = r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_FETCH || r_state == ST_MEM) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_next == ST_FAULT) begin
                r_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_PC4;
        alu_src_a     = ALU_A_RS1;
        alu_src_b     = ALU_B_RS2;
        alu_op        = ALUOP_ADD;
        imm_type      = w_imm_raw;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        instr_retired = 1'b0;
        trap          = 1'b0;

        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_timeout) begin
                    w_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                alu_src_a = ALU_A_PC;
                alu_src_b = ALU_B_IMM;
                w_next    = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (w_cls)
                    CLS_OP: begin
                        alu_op = ALUOP_FUNCT;
                        w_next = ST_WB;
                    end
                    CLS_OPIMM: begin
                        alu_src_b = ALU_B_IMM;
                        alu_op    = ALUOP_FUNCT;
                        w_next    = ST_WB;
                    end
                    CLS_LUI: begin
                        alu_src_a = ALU_A_ZERO;
                        alu_src_b = ALU_B_IMM;
                        w_next    = ST_WB;
                    end
                    CLS_AUIPC: begin
                        alu_src_a = ALU_A_PC;
                        alu_src_b = ALU_B_IMM;
                        w_next    = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b = ALU_B_IMM;
                        w_next    = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op        = ALUOP_CMP;
                        pc_write      = 1'b1;
                        pc_src        = branch_taken ? PC_SRC_ALU : PC_SRC_PC4;
                        instr_retired = 1'b1;
                        w_next        = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        // JAL target comes from DECODE; JALR recomputes rs1 + imm.
                        if (w_cls == CLS_JALR) begin
                            alu_src_b = ALU_B_IMM;
                        end
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_ALU;
                        w_next   = ST_WB;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        w_next = ST_TRAP;
`else
                        pc_write      = 1'b1;
                        pc_src        = PC_SRC_PC4;
                        instr_retired = 1'b1;
                        w_next        = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (w_cls == CLS_STORE);
                if (mem_ready) begin
                    if (w_cls == CLS_STORE) begin
                        pc_write      = 1'b1;
                        pc_src        = PC_SRC_PC4;
                        instr_retired = 1'b1;
                        w_next        = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_next = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_write     = 1'b1;
                wb_sel        = (w_cls == CLS_LOAD) ? WB_MEM : (w_is_jump ? WB_PC4 : WB_ALU);
                pc_write      = !w_is_jump;
                pc_src        = PC_SRC_PC4;
                instr_retired = 1'b1;
                w_next        = ST_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: begin
                trap     = 1'b1;
                pc_write = 1'b1;
                pc_src   = PC_SRC_TRAP;
                w_next   = ST_FETCH;
            end
`endif
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase

        // Strobes are suppressed while reset is held so a pending request is abandoned.
        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            instr_retired = 1'b0;
            trap          = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_controller
// Brief   : Directed self-checking bench for multicycle_controller (MEM_TIMEOUT = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;
    import core_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [2:0] imm_type;
    logic       reg_write, instr_retired, trap, fault;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct3        (funct3),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_type      (imm_type),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .instr_retired (instr_retired),
        .trap          (trap),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic ok);
        n_assert++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = OPC_OPIMM; funct3 = 3'd0; branch_taken = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_mem_req", mem_req === 1'b0);
            check("rst_ir_write", ir_write === 1'b0);
            check("rst_retired", instr_retired === 1'b0);
        end
        check("rst_fault", fault === 1'b0);

        rst = 1'b0; #1;
        check("addi_c1_mem_req", mem_req === 1'b1);
        check("addi_c1_addr_sel", mem_addr_sel === 1'b0);
        check("addi_c1_ir_write", ir_write === 1'b1);
        step();
        check("addi_c2_src_a", alu_src_a === 2'd1);
        check("addi_c2_src_b", alu_src_b === 2'd1);
        check("addi_c2_imm", imm_type === 3'd0);
        check("addi_c2_mem_req", mem_req === 1'b0);
        step();
        check("addi_c3_alu_op", alu_op === 2'd2);
        check("addi_c3_src_b", alu_src_b === 2'd1);
        check("addi_c3_retired", instr_retired === 1'b0);
        step();
        check("addi_c4_reg_write", reg_write === 1'b1);
        check("addi_c4_wb_sel", wb_sel === 2'd0);
        check("addi_c4_pc_write", pc_write === 1'b1);
        check("addi_c4_pc_src", pc_src === 2'd0);
        check("addi_c4_retired", instr_retired === 1'b1);
        check("addi_c4_imm", imm_type === 3'd0);

        step(); opcode = OPC_LOAD; #1;
        check("lw_c1_ir_write", ir_write === 1'b1);
        step();
        check("lw_c2_imm", imm_type === 3'd0);
        step(); mem_ready = 1'b0; #1;
        check("lw_c3_src_a", alu_src_a === 2'd0);
        check("lw_c3_src_b", alu_src_b === 2'd1);
        check("lw_c3_mem_req", mem_req === 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lw_wait_mem_req", mem_req === 1'b1);
            check("lw_wait_addr_sel", mem_addr_sel === 1'b1);
            check("lw_wait_we", mem_we === 1'b0);
            check("lw_wait_retired", instr_retired === 1'b0);
        end
        step(); mem_ready = 1'b1; #1;
        check("lw_c7_mem_req", mem_req === 1'b1);
        step();
        check("lw_c8_mem_req", mem_req === 1'b0);
        check("lw_c8_reg_write", reg_write === 1'b1);
        check("lw_c8_wb_sel", wb_sel === 2'd1);
        check("lw_c8_retired", instr_retired === 1'b1);
        check("lw_c8_fault", fault === 1'b0);

        step(); opcode = OPC_STORE; #1;
        step();
        check("sw_c2_imm", imm_type === 3'd1);
        step();
        step();
        check("sw_c4_we", mem_we === 1'b1);
        check("sw_c4_mem_req", mem_req === 1'b1);
        check("sw_c4_pc_write", pc_write === 1'b1);
        check("sw_c4_pc_src", pc_src === 2'd0);
        check("sw_c4_retired", instr_retired === 1'b1);
        check("sw_c4_reg_write", reg_write === 1'b0);

        step(); opcode = OPC_BRANCH; branch_taken = 1'b1; #1;
        step();
        check("beq_c2_imm", imm_type === 3'd2);
        step();
        check("beqt_c3_alu_op", alu_op === 2'd1);
        check("beqt_c3_pc_write", pc_write === 1'b1);
        check("beqt_c3_pc_src", pc_src === 2'd1);
        check("beqt_c3_retired", instr_retired === 1'b1);
        step(); branch_taken = 1'b0; #1;
        check("beqn_c1_mem_req", mem_req === 1'b1);
        step();
        step();
        check("beqn_c3_pc_src", pc_src === 2'd0);
        check("beqn_c3_retired", instr_retired === 1'b1);

        step(); opcode = OPC_JAL; #1;
        step();
        check("jal_c2_imm", imm_type === 3'd4);
        step();
        check("jal_c3_pc_write", pc_write === 1'b1);
        check("jal_c3_pc_src", pc_src === 2'd1);
        check("jal_c3_retired", instr_retired === 1'b0);
        step();
        check("jal_c4_reg_write", reg_write === 1'b1);
        check("jal_c4_wb_sel", wb_sel === 2'd2);
        check("jal_c4_pc_write", pc_write === 1'b0);
        check("jal_c4_retired", instr_retired === 1'b1);

        step(); opcode = 7'h7F; #1;
        step();
        step();
`ifdef ILLEGAL_TRAP_EN
        check("ill_c3_retired", instr_retired === 1'b0);
        check("ill_c3_pc_write", pc_write === 1'b0);
        step();
        check("trap_c4_trap", trap === 1'b1);
        check("trap_c4_pc_write", pc_write === 1'b1);
        check("trap_c4_pc_src", pc_src === 2'd2);
        check("trap_c4_retired", instr_retired === 1'b0);
        check("trap_c4_reg_write", reg_write === 1'b0);
        step();
        check("trap_c5_trap", trap === 1'b0);
`else
        check("nop_c3_pc_write", pc_write === 1'b1);
        check("nop_c3_pc_src", pc_src === 2'd0);
        check("nop_c3_retired", instr_retired === 1'b1);
        check("nop_c3_trap", trap === 1'b0);
        step();
`endif
        check("after_ill_mem_req", mem_req === 1'b1);

        mem_ready = 1'b0; #1;
        check("to_c1_mem_req", mem_req === 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_wait_mem_req", mem_req === 1'b1);
            check("to_wait_fault", fault === 1'b0);
        end
        step();
        check("to_fault", fault === 1'b1);
        check("to_fault_mem_req", mem_req === 1'b0);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fault_mem_req", mem_req === 1'b0);
            check("fault_ir_write", ir_write === 1'b0);
            check("fault_pc_write", pc_write === 1'b0);
            check("fault_reg_write", reg_write === 1'b0);
            check("fault_retired", instr_retired === 1'b0);
            check("fault_sticky", fault === 1'b1);
        end
        rst = 1'b1;
        step();
        check("fault_clr", fault === 1'b0);

        rst = 1'b0; opcode = OPC_LOAD; #1;
        check("mid_c1_mem_req", mem_req === 1'b1);
        step();
        step(); mem_ready = 1'b0; #1;
        step();
        check("mid_mem_req", mem_req === 1'b1);
        rst = 1'b1; #1;
        check("mid_rst_mem_req", mem_req === 1'b0);
        check("mid_rst_pc_write", pc_write === 1'b0);
        step(); rst = 1'b0; mem_ready = 1'b1; #1;
        check("mid_after_mem_req", mem_req === 1'b1);
        check("mid_after_addr_sel", mem_addr_sel === 1'b0);
        check("mid_after_reg_write", reg_write === 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
